// File: rtl/jump_key_conditioner_pkg.sv
// Shared input-path definitions for the jump key conditioner: FSM encoding and
// the legal ranges of the debounce and cooldown parameters.
package jump_key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_MIN = 2;
  localparam int DEBOUNCE_MAX = 15;
  localparam int COOLDOWN_MIN = 1;
  localparam int COOLDOWN_MAX = 255;

  // Pins an out-of-range parameter to the nearest legal value.
  function automatic int clamp_range(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/jump_key_conditioner_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; q is the
// second flop and is the only output safe for downstream logic.
module sync_2ff (
  input  logic frame_rt_clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge frame_rt_clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/jump_key_conditioner.sv
// Debounces the jump button, rate-limits jump pulses with a cooldown and counts
// emitted/dropped jumps. Define JUMP_BUFFER_EN to hold one press during cooldown.
module jump_key_conditioner
  import jump_key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       frame_rt_clk,
  input  logic       reset,
  input  logic       raw_btn,
  output logic       jump_key,
  output logic       btn_held,
  output logic [7:0] jump_count,
  output logic [3:0] drop_count
);

  localparam logic [3:0] DB_TARGET = 4'(clamp_range(DEBOUNCE_FRAMES, DEBOUNCE_MIN, DEBOUNCE_MAX));
  localparam logic [7:0] CD_LOAD   = 8'(clamp_range(COOLDOWN_FRAMES, COOLDOWN_MIN, COOLDOWN_MAX));

  logic       sync;
  btn_state_t state_reg, state_next;
  logic [3:0] db_cnt_reg, db_cnt_next;
  logic [3:0] db_inc;
  logic [7:0] cd_cnt_reg;
  logic       press_event;
  logic       emit;
  logic       drop;

  sync_2ff u_sync (
    .frame_rt_clk (frame_rt_clk),
    .reset        (reset),
    .d            (raw_btn),
    .q            (sync)
  );

  assign db_inc   = db_cnt_reg + 4'd1;
  assign btn_held = (state_reg == PRESSED) || (state_reg == REL_PEND);

  always_comb begin
    state_next  = state_reg;
    db_cnt_next = db_cnt_reg;
    press_event = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync) begin
          state_next  = PRESS_PEND;
          db_cnt_next = 4'd1;
        end
      end
      PRESS_PEND: begin
        if (!sync) begin
          state_next = IDLE;
        end else if (db_inc == DB_TARGET) begin
          state_next  = PRESSED;
          press_event = 1'b1;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next  = REL_PEND;
          db_cnt_next = 4'd1;
        end
      end
      REL_PEND: begin
        // A bounce back high returns to PRESSED without a second press event.
        if (sync) begin
          state_next = PRESSED;
        end else if (db_inc == DB_TARGET) begin
          state_next = IDLE;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef JUMP_BUFFER_EN
  logic buf_reg, buf_next;

  // When the buffer drains on the same edge as a new press, the new press
  // takes the buffer slot instead of being lost.
  always_comb begin
    emit     = 1'b0;
    drop     = 1'b0;
    buf_next = buf_reg;
    if (cd_cnt_reg == 8'd0) begin
      emit     = buf_reg | press_event;
      buf_next = buf_reg & press_event;
    end else if (press_event) begin
      if (buf_reg) drop = 1'b1;
      else         buf_next = 1'b1;
    end
  end

  always_ff @(posedge frame_rt_clk or posedge reset) begin
    if (reset) buf_reg <= 1'b0;
    else       buf_reg <= buf_next;
  end
`else
  assign emit = press_event && (cd_cnt_reg == 8'd0);
  assign drop = press_event && (cd_cnt_reg != 8'd0);
`endif

  always_ff @(posedge frame_rt_clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      db_cnt_reg <= 4'd0;
      cd_cnt_reg <= 8'd0;
      jump_key   <= 1'b0;
      jump_count <= 8'd0;
      drop_count <= 4'd0;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
      jump_key   <= emit;
      if (emit)                      cd_cnt_reg <= CD_LOAD;
      else if (cd_cnt_reg != 8'd0)   cd_cnt_reg <= cd_cnt_reg - 8'd1;
      if (emit)                      jump_count <= jump_count + 8'd1;
      if (drop && drop_count != 4'hF) drop_count <= drop_count + 4'd1;
    end
  end

endmodule

// File: tb/tb_jump_key_conditioner.sv
// Scoreboard bench for jump_key_conditioner: expected jump edges are queued as
// stimulus is driven and popped when jump_key is seen.
module tb_jump_key_conditioner;

  localparam int D = 2;
  localparam int C = 8;
`ifdef JUMP_BUFFER_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif

  logic       frame_rt_clk;
  logic       reset;
  logic       raw_btn;
  logic       jump_key;
  logic       btn_held;
  logic [7:0] jump_count;
  logic [3:0] drop_count;

  int edge_n    = 0;
  int n_checks  = 0;
  int n_pass    = 0;
  int last_jump = -1000;
  int exp_e;
  bit sb_on     = 1'b1;
  int sb[$];

  jump_key_conditioner #(
    .DEBOUNCE_FRAMES (D),
    .COOLDOWN_FRAMES (C)
  ) dut (
    .frame_rt_clk (frame_rt_clk),
    .reset        (reset),
    .raw_btn      (raw_btn),
    .jump_key     (jump_key),
    .btn_held     (btn_held),
    .jump_count   (jump_count),
    .drop_count   (drop_count)
  );

  initial begin
    frame_rt_clk = 1'b0;
    forever #5 frame_rt_clk = ~frame_rt_clk;
  end

  always @(posedge frame_rt_clk) edge_n++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  // Jump monitor: every pulse must match the head of the scoreboard.
  always @(negedge frame_rt_clk) begin
    if (reset) begin
      last_jump = -1000;
    end else if (jump_key) begin
      check_val("jump_spacing", 32'(edge_n - last_jump >= C + 1), 1);
      last_jump = edge_n;
      if (sb_on) begin
        if (sb.size() == 0) begin
          check_val("jump_unexpected", 32'(jump_key), 0);
        end else begin
          exp_e = sb.pop_front();
          check_val("jump_edge", edge_n, exp_e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge frame_rt_clk);
  endtask

  // Drives pat[i] before edge base+i, then returns raw_btn low.
  task automatic drive_seq(input logic [31:0] pat, input int len, input int e1, input int e2,
                           output int base);
    logic [31:0] p;
    p = pat;
    @(negedge frame_rt_clk);
    base = edge_n + 1;
    if (e1 >= 0) sb.push_back(base + e1);
    if (e2 >= 0) sb.push_back(base + e2);
    for (int i = 0; i < len; i++) begin
      raw_btn = p[i];
      @(negedge frame_rt_clk);
    end
    raw_btn = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic sb_drained(input string tag);
    check_val(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int b;
    int f;
    int base;
    reset   = 1'b1;
    raw_btn = 1'b0;
    idle(3);
    check_val("rst_jump_key", 32'(jump_key), 0);
    check_val("rst_btn_held", 32'(btn_held), 0);
    check_val("rst_jump_count", 32'(jump_count), 0);
    check_val("rst_drop_count", 32'(drop_count), 0);
    reset = 1'b0;
    idle(3);

    // Clean held press: jump D+1 edges after the sync chain settles
    @(negedge frame_rt_clk);
    raw_btn = 1'b1;
    b = edge_n + 1;
    sb.push_back(b + 1 + D);
    for (int i = 0; i < 6; i++) begin
      @(negedge frame_rt_clk);
      check_val("held_press", 32'(btn_held), 32'(i >= 1 + D));
    end
    idle(4);
    raw_btn = 1'b0;
    idle(20);
    sb_drained("press_missing");
    check_val("press_count", 32'(jump_count), 1);
    check_val("press_released", 32'(btn_held), 0);

    // Single-cycle bounces never survive debounce
    for (int i = 0; i < 10; i++) begin
      @(negedge frame_rt_clk);
      raw_btn = ~raw_btn;
      check_val("bounce_held", 32'(btn_held), 0);
    end
    raw_btn = 1'b0;
    idle(10);
    check_val("bounce_count", 32'(jump_count), 1);

    // Two press events 4 edges apart: second lands in cooldown
    drive_seq(32'b110011, 6, 3, BUF_ON ? 3 + C + 1 : -1, base);
    idle(30);
    sb_drained("cooldown_missing");
    check_val("cooldown_jump_count", 32'(jump_count), BUF_ON ? 3 : 2);
    check_val("cooldown_drop_count", 32'(drop_count), BUF_ON ? 0 : 1);

    // Reset in PRESS_PEND, released with the button still held
    @(negedge frame_rt_clk);
    raw_btn = 1'b1;
    b = edge_n + 1;
    idle(3);
    reset = 1'b1;
    @(negedge frame_rt_clk);
    check_val("midrst_jump_key", 32'(jump_key), 0);
    check_val("midrst_btn_held", 32'(btn_held), 0);
    check_val("midrst_jump_count", 32'(jump_count), 0);
    check_val("midrst_drop_count", 32'(drop_count), 0);
    @(negedge frame_rt_clk);
    reset = 1'b0;
    f = edge_n + 1;
    sb.push_back(f + 1 + D);
    idle(3);
    check_val("postrst_early", 32'(jump_count), 0);
    idle(5);
    raw_btn = 1'b0;
    idle(30);
    sb_drained("postrst_missing");
    check_val("postrst_count", 32'(jump_count), 1);

    // 256 spaced presses wrap jump_count
    apply_reset();
    for (int n = 0; n < 256; n++) begin
      drive_seq(32'b11, 10, 3, -1, base);
      if (n == 254) check_val("count_255", 32'(jump_count), 255);
    end
    idle(5);
    sb_drained("wrap_missing");
    check_val("count_wrap", 32'(jump_count), 0);

    // Rapid presses: many land in cooldown, drop_count saturates
    sb_on = 1'b0;
    for (int n = 0; n < 80; n++) drive_seq(32'b0011, 4, -1, -1, base);
    idle(30);
    check_val("drop_saturate", 32'(drop_count), 15);
    check_val("drop_idle_jump", 32'(jump_key), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
